// File: rtl/fb_write_sched_if.sv
// Frame-buffer write-port bundle: two pixel requesters, fill-engine control
// and the registered RAM write port.
interface fb_write_sched_if #(
  parameter int CW = 8,
  parameter int DW = 12
);
  logic              req_a;
  logic [2*CW-1:0]   addr_a;
  logic [DW-1:0]     data_a;
  logic              gnt_a;
  logic              req_b;
  logic [2*CW-1:0]   addr_b;
  logic [DW-1:0]     data_b;
  logic              gnt_b;
  logic              fill_start;
  logic [CW-1:0]     fill_x0;
  logic [CW-1:0]     fill_y0;
  logic [CW-1:0]     fill_x1;
  logic [CW-1:0]     fill_y1;
  logic [DW-1:0]     fill_color;
  logic              fill_busy;
  logic              fill_done;
  logic              mem_we;
  logic [2*CW-1:0]   mem_addr;
  logic [DW-1:0]     mem_data;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b,
    output fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    input  gnt_a, gnt_b, fill_busy, fill_done, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b,
    input  fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    output gnt_a, gnt_b, fill_busy, fill_done, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/fb_write_sched.sv
// Frame-buffer write-port scheduler: round-robin between two pixel requesters,
// interleaved with a rectangle fill engine; all RAM write outputs registered.
module fb_write_sched #(
  parameter int CW = 8,
  parameter int DW = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  fb_write_sched_if.slave bus
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state_q, state_d;
  logic            rr_b_q, rr_b_d;          // last client winner was B
  logic            last_fill_q, last_fill_d;
  logic [CW-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [CW-1:0]   x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
  logic [DW-1:0]   color_q, color_d;
  logic            mem_we_q, mem_we_d;
  logic [2*CW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_data_q, mem_data_d;
  logic            fill_done_q, fill_done_d;
  logic            win_a, win_b, serve;

  always_comb begin
    win_a       = bus.req_a & (~bus.req_b | rr_b_q);
    win_b       = bus.req_b & ~win_a;
    state_d     = state_q;
    rr_b_d      = rr_b_q;
    last_fill_d = last_fill_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    color_d     = color_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    fill_done_d = 1'b0;
    serve       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.fill_start) begin
          x0_d    = bus.fill_x0;
          x1_d    = bus.fill_x1;
          y1_d    = bus.fill_y1;
          color_d = bus.fill_color;
          if ((bus.fill_x0 > bus.fill_x1) || (bus.fill_y0 > bus.fill_y1)) begin
            fill_done_d = 1'b1;
          end else begin
            state_d     = FILL;
            cx_d        = bus.fill_x0;
            cy_d        = bus.fill_y0;
            last_fill_d = 1'b0;
          end
        end else begin
          serve = 1'b1;
        end
      end
      FILL: begin
        if (last_fill_q && (bus.req_a || bus.req_b)) begin
          serve       = 1'b1;
          last_fill_d = 1'b0;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {cy_q, cx_q};
          mem_data_d  = color_q;
          last_fill_d = 1'b1;
          // compare before increment so a corner at 255 never wraps the cursor
          if (cx_q == x1_q) begin
            cx_d = x0_q;
            if (cy_q == y1_q) begin
              fill_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              cy_d = cy_q + CW'(1);
            end
          end else begin
            cx_d = cx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (serve && (win_a || win_b)) begin
      mem_we_d   = 1'b1;
      rr_b_d     = win_b;
      mem_addr_d = win_a ? bus.addr_a : bus.addr_b;
      mem_data_d = win_a ? bus.data_a : bus.data_b;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      rr_b_q      <= 1'b1;
      last_fill_q <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_b_q      <= rr_b_d;
      last_fill_q <= last_fill_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign bus.gnt_a     = serve & win_a;
  assign bus.gnt_b     = serve & win_b;
  assign bus.fill_busy = (state_q == FILL);
  assign bus.fill_done = fill_done_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Bench for fb_write_sched: a per-cycle reference model built from the
// arbitration/fill rules plus directed scenarios and randomized traffic.
module tb_fb_write_sched;
  localparam int CW = 8;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fb_write_sched_if #(.CW(CW), .DW(DW)) bus();
  fb_write_sched #(.CW(CW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_fill, m_lastfill, m_rr_b;
  logic [11:0] m_color;
  logic [15:0] fq[$];
  logic        p_we, p_done;
  logic [15:0] p_addr;
  logic [11:0] p_data;

  // observations
  logic        s_gnt_a, s_gnt_b, s_done;
  logic [15:0] wl_addr[$];
  logic [11:0] wl_data[$];
  int          busy_cycles;
  int          a_mode, b_mode;   // 0 drop after grant, 1 keep requesting, 2 random

  task automatic model_reset();
    m_fill = 0; m_lastfill = 0; m_rr_b = 1; m_color = '0; fq.delete();
    p_we = 0; p_done = 0; p_addr = '0; p_data = '0;
  endtask

  task automatic clear_obs();
    wl_addr.delete(); wl_data.delete(); s_done = 0; busy_cycles = 0;
  endtask

  task automatic start_fill(input int x0, input int y0, input int x1, input int y1,
                            input logic [11:0] color);
    bus.fill_x0 = 8'(x0); bus.fill_y0 = 8'(y0);
    bus.fill_x1 = 8'(x1); bus.fill_y1 = 8'(y1);
    bus.fill_color = color; bus.fill_start = 1'b1;
  endtask

  // one clock: sample at negedge against the model, then update stimulus after posedge
  task automatic tick();
    logic ea, eb, arb;
    int xa, xb, ya, yb;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== p_we) begin
      errors++; $display("FAIL mem_we: got %b expected %b at %0t", bus.mem_we, p_we, $time);
    end else if (p_we) begin
      checks++;
      if (bus.mem_addr !== p_addr || bus.mem_data !== p_data) begin
        errors++;
        $display("FAIL mem_write: got %h/%h expected %h/%h at %0t",
                 bus.mem_addr, bus.mem_data, p_addr, p_data, $time);
      end
    end
    checks++;
    if (bus.fill_done !== p_done) begin
      errors++; $display("FAIL fill_done: got %b expected %b at %0t", bus.fill_done, p_done, $time);
    end
    checks++;
    if (bus.fill_busy !== m_fill) begin
      errors++; $display("FAIL fill_busy: got %b expected %b at %0t", bus.fill_busy, m_fill, $time);
    end
    if (bus.mem_we === 1'b1) begin
      wl_addr.push_back(bus.mem_addr); wl_data.push_back(bus.mem_data);
    end
    if (bus.fill_done === 1'b1) s_done = 1;
    if (bus.fill_busy === 1'b1) busy_cycles++;

    arb = m_fill ? m_lastfill : !bus.fill_start;
    ea  = arb && bus.req_a && (!bus.req_b || m_rr_b);
    eb  = arb && bus.req_b && !ea;
    checks++;
    if (bus.gnt_a !== ea || bus.gnt_b !== eb) begin
      errors++;
      $display("FAIL grant: got a=%b b=%b expected a=%b b=%b at %0t",
               bus.gnt_a, bus.gnt_b, ea, eb, $time);
    end
    s_gnt_a = bus.gnt_a; s_gnt_b = bus.gnt_b;

    p_we = 0; p_done = 0;
    if (ea || eb) begin
      p_we = 1; p_addr = ea ? bus.addr_a : bus.addr_b;
      p_data = ea ? bus.data_a : bus.data_b;
      m_rr_b = eb; m_lastfill = 0;
    end else if (m_fill) begin
      p_we = 1; p_addr = fq.pop_front(); p_data = m_color; m_lastfill = 1;
      if (fq.size() == 0) begin p_done = 1; m_fill = 0; end
    end else if (bus.fill_start) begin
      m_color = bus.fill_color; fq.delete();
      xa = int'(bus.fill_x0); xb = int'(bus.fill_x1);
      ya = int'(bus.fill_y0); yb = int'(bus.fill_y1);
      for (int y = ya; y <= yb; y++)
        for (int x = xa; x <= xb; x++)
          fq.push_back({y[7:0], x[7:0]});
      if (fq.size() == 0) p_done = 1;
      else begin m_fill = 1; m_lastfill = 0; end
    end

    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    if (!bus.req_a || s_gnt_a) begin
      bus.req_a  = (a_mode == 1) || (a_mode == 2 && $urandom_range(0, 1) == 1);
      bus.addr_a = 16'($urandom);
      bus.data_a = 12'($urandom_range(0, 12'hEFF));
    end
    if (!bus.req_b || s_gnt_b) begin
      bus.req_b  = (b_mode == 1) || (b_mode == 2 && $urandom_range(0, 1) == 1);
      bus.addr_b = 16'($urandom);
      bus.data_b = 12'($urandom_range(0, 12'hEFF));
    end
  endtask

  task automatic drain();
    a_mode = 0; b_mode = 0;
    repeat (8) tick();
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !s_done; i++) tick();
    checks++;
    if (!s_done) begin
      errors++; $display("FAIL fill_timeout: fill_done not seen within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_data !== 12'h0 ||
        bus.fill_done !== 1'b0 || bus.fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: we=%b addr=%h data=%h done=%b busy=%b expected all zero",
               bus.mem_we, bus.mem_addr, bus.mem_data, bus.fill_done, bus.fill_busy);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
  endtask

  task automatic test_ties();
    clear_obs();
    a_mode = 1; b_mode = 1;
    bus.req_a = 1; bus.addr_a = 16'h1111; bus.data_a = 12'h111;
    bus.req_b = 1; bus.addr_b = 16'h2222; bus.data_b = 12'h222;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (s_gnt_a !== (i % 2 == 0) || s_gnt_b !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL tie_order[%0d]: got a=%b b=%b expected a=%b b=%b",
                 i, s_gnt_a, s_gnt_b, (i % 2 == 0), (i % 2 == 1));
      end
    end
    tick();
    checks++;
    if (wl_addr.size() != 4 || wl_addr[0] !== 16'h1111 || wl_data[1] !== 12'h222) begin
      errors++;
      $display("FAIL tie_writes: got %0d writes first=%h expected 4 writes first=1111",
               wl_addr.size(), (wl_addr.size() > 0) ? wl_addr[0] : 16'h0);
    end
    drain();
  endtask

  task automatic test_fill_plain();
    logic [15:0] exp6 [6] = '{16'h0102, 16'h0103, 16'h0104, 16'h0202, 16'h0203, 16'h0204};
    clear_obs();
    start_fill(2, 1, 4, 2, 12'hF00);
    tick();
    wait_done(50);
    checks++;
    if (wl_addr.size() != 6) begin
      errors++; $display("FAIL fill_count: got %0d writes expected 6", wl_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wl_addr[i] !== exp6[i] || wl_data[i] !== 12'hF00) begin
          errors++;
          $display("FAIL fill_write[%0d]: got %h/%h expected %h/f00", i, wl_addr[i], wl_data[i], exp6[i]);
        end
      end
    end
    checks++;
    if (busy_cycles != 6) begin
      errors++; $display("FAIL fill_busy_len: got %0d cycles expected 6", busy_cycles);
    end
    drain();
  endtask

  task automatic test_fill_contention();
    logic [15:0] exp6 [6] = '{16'h0102, 16'h0103, 16'h0104, 16'h0202, 16'h0203, 16'h0204};
    clear_obs();
    a_mode = 1;
    bus.req_a = 1; bus.addr_a = 16'h5555; bus.data_a = 12'h0A5;
    start_fill(2, 1, 4, 2, 12'hF00);
    tick();
    checks++;
    if (s_gnt_a !== 1'b0) begin
      errors++; $display("FAIL start_priority: gnt_a got %b expected 0", s_gnt_a);
    end
    wait_done(60);
    checks++;
    if (wl_addr.size() != 11) begin
      errors++; $display("FAIL contention_count: got %0d writes expected 11", wl_addr.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if ((i % 2 == 0) ? (wl_addr[i] !== exp6[i/2] || wl_data[i] !== 12'hF00)
                         : (wl_data[i] === 12'hF00)) begin
          errors++;
          $display("FAIL contention_order[%0d]: got %h/%h", i, wl_addr[i], wl_data[i]);
        end
      end
    end
    drain();
  endtask

  task automatic test_edges();
    clear_obs();
    start_fill(5, 0, 4, 0, 12'h123);
    tick();
    tick();
    checks++;
    if (s_done !== 1'b1 || wl_addr.size() != 0) begin
      errors++;
      $display("FAIL empty_rect: done=%b writes=%0d expected done=1 writes=0", s_done, wl_addr.size());
    end
    repeat (2) tick();
    clear_obs();
    start_fill(255, 255, 255, 255, 12'hABC);
    tick();
    wait_done(10);
    repeat (4) tick();
    checks++;
    if (wl_addr.size() != 1 || wl_addr[0] !== 16'hFFFF || wl_data[0] !== 12'hABC) begin
      errors++;
      $display("FAIL corner_rect: writes=%0d first=%h expected 1 write to ffff",
               wl_addr.size(), (wl_addr.size() > 0) ? wl_addr[0] : 16'h0);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    int nfill;
    clear_obs();
    b_mode = 0;
    bus.req_b = 1; bus.addr_b = 16'h7777; bus.data_b = 12'h077;
    start_fill(0, 0, 2, 0, 12'hF0F);
    tick();
    checks++;
    if (s_gnt_b !== 1'b0) begin
      errors++; $display("FAIL start_vs_b: gnt_b got %b expected 0", s_gnt_b);
    end
    start_fill(0, 0, 9, 9, 12'hF0F);
    tick();
    wait_done(40);
    repeat (6) tick();
    nfill = 0;
    foreach (wl_data[i]) if (wl_data[i] === 12'hF0F) nfill++;
    checks++;
    if (nfill != 3 || wl_addr.size() != 4) begin
      errors++;
      $display("FAIL start_in_fill: fill writes=%0d total=%0d expected 3 and 4", nfill, wl_addr.size());
    end
    drain();
  endtask

  task automatic test_random();
    int x0, y0, w, h;
    for (int n = 0; n < 40; n++) begin
      clear_obs();
      a_mode = $urandom_range(0, 2); b_mode = $urandom_range(0, 2);
      x0 = $urandom_range(0, 255); y0 = $urandom_range(0, 255);
      w = $urandom_range(0, 5); h = $urandom_range(0, 4);
      if (x0 + w > 255) w = 255 - x0;
      if (y0 + h > 255) h = 255 - y0;
      if ($urandom_range(0, 7) == 0) start_fill(x0 + 1 + w, y0, x0, y0 + h, 12'($urandom));
      else start_fill(x0, y0, x0 + w, y0 + h, 12'($urandom));
      tick();
      for (int i = 0; i < 200 && !s_done; i++) begin
        if (m_fill && $urandom_range(0, 9) == 0) start_fill(0, 0, 255, 255, 12'h0);
        tick();
      end
      checks++;
      if (!s_done) begin
        errors++; $display("FAIL random_fill_timeout: iteration %0d", n);
      end
      drain();
    end
  endtask

  task automatic test_reset_midfill();
    logic found;
    clear_obs();
    found = 0;
    start_fill(0, 0, 15, 5, 12'h5A5);
    tick();
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (fq.size() > 0 && fq[0] == 16'h030A) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midfill_reach: cursor (10,3) not reached");
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_data !== 12'h0 ||
        bus.fill_done !== 1'b0 || bus.fill_busy !== 1'b0 || bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0) begin
      errors++;
      $display("FAIL midfill_reset: we=%b addr=%h data=%h done=%b busy=%b expected all zero",
               bus.mem_we, bus.mem_addr, bus.mem_data, bus.fill_done, bus.fill_busy);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    s_done = 0;
    repeat (5) tick();
    checks++;
    if (s_done !== 1'b0) begin
      errors++; $display("FAIL midfill_no_done: fill_done got 1 expected 0 after reset");
    end
    bus.req_a = 1; bus.addr_a = 16'h0A0A; bus.data_a = 12'h00A;
    bus.req_b = 1; bus.addr_b = 16'h0B0B; bus.data_b = 12'h00B;
    tick();
    checks++;
    if (s_gnt_a !== 1'b1 || s_gnt_b !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_tie: got a=%b b=%b expected a=1 b=0", s_gnt_a, s_gnt_b);
    end
    drain();
  endtask

  initial begin
    a_mode = 0; b_mode = 0;
    bus.req_a = 0; bus.addr_a = '0; bus.data_a = '0;
    bus.req_b = 0; bus.addr_b = '0; bus.data_b = '0;
    bus.fill_start = 0; bus.fill_x0 = '0; bus.fill_y0 = '0;
    bus.fill_x1 = '0; bus.fill_y1 = '0; bus.fill_color = '0;
    model_reset();
    clear_obs();
    s_gnt_a = 0; s_gnt_b = 0;
    test_reset();
    test_ties();
    test_fill_plain();
    test_fill_contention();
    test_edges();
    test_simultaneous();
    test_random();
    test_reset_midfill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fb_write_sched.md
Name: fb_write_sched

Overview:
- Scheduler for the single write port of the 256x256x12 frame-buffer RAM (the dual-port video memory whose read port feeds the VGA display unit).
- Shares the write port between two pixel requesters (A: paint control unit, B: secondary painter such as a cursor or sprite) using round-robin arbitration.
- Contains a rectangle fill engine for screen clear and box fill, which interleaves with client writes so neither side starves.
- All RAM write outputs are registered.

Parameters:
- CW, 8, coordinate width; memory address = {y,x}, 2*CW bits.
- DW, 12, pixel width (RGB444).

Ports:
- clk  in  1  system clock (the clock that drives the RAM write port).
- rst_n  in  1  asynchronous, active-high reset (port keeps the codebase name; high = reset).
- req_a  in  1  requester A write request; held with addr/data until granted.
- addr_a  in  2*CW  requester A address {y,x}.
- data_a  in  DW  requester A pixel.
- gnt_a  out  1  combinational; high in the cycle A's write is accepted at the next edge.
- req_b, addr_b, data_b, gnt_b: same as A, for requester B.
- fill_start  in  1  one-cycle start pulse for the fill engine.
- fill_x0, fill_y0, fill_x1, fill_y1  in  CW each  inclusive rectangle; latched on start.
- fill_color  in  DW  fill pixel; latched on start.
- fill_busy  out  1  high while in state FILL.
- fill_done  out  1  one-cycle pulse on completion.
- mem_we  out  1  registered RAM write enable.
- mem_addr  out  2*CW  registered RAM address.
- mem_data  out  DW  registered RAM data.

Behaviour:
- Reset (async): state IDLE. mem_we, mem_addr, mem_data, fill_done = 0. rrp (round-robin pointer) = B, so A wins the first tie. Latched fill registers cleared.
- Reset mid-fill: abandons the fill immediately, with no fill_done pulse.
- States: IDLE, FILL.
- Client arbitration (used in both states):
  - Only one requester active: it wins.
  - Both active: the one not equal to rrp wins.
  - rrp updates to the winner on every client grant.
  - gnt_x = that requester would win this cycle. At the edge, mem_we=1, mem_addr=addr_x, mem_data=data_x, so latency is 1 cycle from grant to RAM write.
  - The requester advances on the edge where it sees gnt.
  - Any edge with no write issued: mem_we=0; mem_addr/mem_data hold their values.
- IDLE:
  - fill_start=1 has priority over clients: no grant that cycle. Latch rectangle and color.
  - If x0>x1 or y0>y1: stay IDLE, pulse fill_done on the next cycle, issue no writes.
  - Otherwise: go to FILL with cursor=(x0,y0) and lastfill=0.
  - Else: serve clients as described above.
- FILL (one write per edge):
  - If lastfill=1 and (req_a|req_b): issue a client write via round-robin. Cursor holds. lastfill=0.
  - Otherwise: issue a fill write at {cy,cx} with the latched color. lastfill=1. gnt_a=gnt_b=0.
  - Cursor sequence: x increments; at x1 it wraps to x0 and y increments.
  - Fill write at (x1,y1): fill_done=1 registered on the same edge as that mem_we. State returns to IDLE, fill_busy=0.
  - fill_start during FILL: ignored.
  - Total fill writes = (x1-x0+1)*(y1-y0+1). Full screen = 65536 writes in 65536 to 131072 cycles.
- Arithmetic: cursor counters are CW bits. Compare against x1/y1 before incrementing so that x1=255 never overflows.
- fill_busy = (state==FILL), registered.

Test Plan:
- Reset mid-operation: assert rst_n during a fill at cursor (10,3) -> all outputs 0 immediately, no fill_done. First post-reset req_a/req_b tie grants A.
- Ties: req_a and req_b held high for 4 cycles with distinct addrs -> grants A,B,A,B. mem_we high 4 consecutive cycles, each mem_addr/mem_data matching the granted requester, delayed 1 cycle.
- Fill with no contention: fill_start with (2,1)-(4,2), color 12'hF00 -> 6 consecutive writes to addrs 0x0102,0x0103,0x0104,0x0202,0x0203,0x0204, all data F00. fill_done coincides with the write to 0x0204. fill_busy high for exactly 6 cycles.
- Fill with contention: same rectangle with req_a held high throughout -> mem writes alternate F,A,F,A,... until 6 fill writes are done. Total 11 writes. gnt_a never high on a fill-write edge.
- Empty and edge cases: rectangle (5,0)-(4,0) -> zero writes, fill_done pulses one cycle after start. Rectangle (255,255)-(255,255) -> exactly one write to 0xFFFF, then done, no wrap.
- Simultaneous events: fill_start and req_b in the same IDLE cycle -> gnt_b=0 that cycle, fill begins. fill_start issued during FILL -> ignored, write count unchanged.
